// File: rtl/audio_fir_sequencer.sv
// Sequences codec sample pairs through a shared FIR engine (left, then right) and writes results back.
// Optional SEQ_ERRCNT_EN: saturating 8-bit count of FIR timeouts on err_count.
module audio_fir_sequencer #(
    parameter int FIR_TIMEOUT = 64
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               read_ready,
    input  logic               write_ready,
    input  logic [23:0]        readdata_left,
    input  logic [23:0]        readdata_right,
    output logic               read,
    output logic               write,
    output logic [23:0]        writedata_left,
    output logic [23:0]        writedata_right,
    output logic               fir_start,
    output logic signed [15:0] fir_in,
    input  logic               fir_done,
    input  logic signed [15:0] fir_out,
    output logic               fir_error,
    output logic [7:0]         err_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_FIR_L, S_WAIT_L, S_FIR_R, S_WAIT_R, S_WAIT_WR, S_WRITE
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(FIR_TIMEOUT - 1);

    state_t             r_state;
    logic               r_read;
    logic               r_write;
    logic               r_fir_start;
    logic signed [15:0] r_fir_in;
    logic signed [15:0] r_samp_l;
    logic signed [15:0] r_samp_r;
    logic signed [15:0] r_res_l;
    logic [23:0]        r_wd_l;
    logic [23:0]        r_wd_r;
    logic [7:0]         r_cnt;
    logic               r_fir_error;

    logic               w_wait;
    logic               w_timeout;
    logic               w_to_event;
    logic               w_advance;
    logic signed [15:0] w_res;
    logic               w_unused;

    assign w_wait     = (r_state == S_WAIT_L) || (r_state == S_WAIT_R);
    // The count reaches FIR_TIMEOUT in this cycle; fir_done in the same cycle still wins.
    assign w_timeout  = (r_cnt == TO_LAST);
    assign w_to_event = w_wait && !fir_done && w_timeout;
    assign w_advance  = fir_done || w_timeout;
    assign w_res      = fir_done ? fir_out : ((r_state == S_WAIT_L) ? r_samp_l : r_samp_r);
    assign w_unused   = ^{readdata_left[7:0], readdata_right[7:0]};

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_fir_start <= 1'b0;
            r_fir_in    <= '0;
            r_samp_l    <= '0;
            r_samp_r    <= '0;
            r_res_l     <= '0;
            r_wd_l      <= '0;
            r_wd_r      <= '0;
            r_cnt       <= '0;
            r_fir_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (read_ready) begin
                        r_read  <= 1'b1;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_read      <= 1'b0;
                    r_samp_l    <= readdata_left[23:8];
                    r_samp_r    <= readdata_right[23:8];
                    r_fir_in    <= readdata_left[23:8];
                    r_fir_start <= 1'b1;
                    r_state     <= S_FIR_L;
                end
                S_FIR_L: begin
                    r_fir_start <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= S_WAIT_L;
                end
                S_WAIT_L: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (w_advance) begin
                        r_res_l     <= w_res;
                        r_fir_in    <= r_samp_r;
                        r_fir_start <= 1'b1;
                        r_state     <= S_FIR_R;
                        if (!fir_done) r_fir_error <= 1'b1;
                    end
                end
                S_FIR_R: begin
                    r_fir_start <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= S_WAIT_R;
                end
                S_WAIT_R: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (w_advance) begin
                        r_wd_l  <= {r_res_l, 8'h00};
                        r_wd_r  <= {w_res, 8'h00};
                        r_state <= S_WAIT_WR;
                        if (!fir_done) r_fir_error <= 1'b1;
                    end
                end
                S_WAIT_WR: begin
                    if (write_ready) begin
                        r_write <= 1'b1;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_write <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SEQ_ERRCNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            r_err_count <= '0;
        else if (w_to_event && (r_err_count != 8'hFF))
            r_err_count <= r_err_count + 8'd1;
    end

    assign err_count = r_err_count;
`else
    logic w_unused_to;
    assign w_unused_to = w_to_event;
    assign err_count   = 8'h00;
`endif

    assign read            = r_read;
    assign write           = r_write;
    assign fir_start       = r_fir_start;
    assign fir_in          = r_fir_in;
    assign writedata_left  = r_wd_l;
    assign writedata_right = r_wd_r;
    assign fir_error       = r_fir_error;

endmodule

// File: tb/tb_audio_fir_sequencer.sv
// Scoreboard bench for audio_fir_sequencer: a behavioural FIR responder with per-channel
// response delay, expected write data/latency queued at stimulus time and checked on write.
module tb_audio_fir_sequencer;

    localparam int TO = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic               read_ready, write_ready;
    logic [23:0]        readdata_left, readdata_right;
    logic               read, write;
    logic [23:0]        writedata_left, writedata_right;
    logic               fir_start;
    logic signed [15:0] fir_in;
    logic               fir_done;
    logic signed [15:0] fir_out;
    logic               fir_error;
    logic [7:0]         err_count;

    typedef struct {
        logic [23:0] wd_l;
        logic [23:0] wd_r;
        int          lat;
    } exp_t;

    exp_t sb[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int read_cyc = 0;
    int read_cnt = 0;
    int write_cnt = 0;
    int d_l = 1, d_r = 1;
    logic signed [15:0] exp_in_l = 0, exp_in_r = 0;
    logic tb_chan = 1'b0;
    logic stray_req = 1'b0;

    audio_fir_sequencer #(.FIR_TIMEOUT(TO)) dut (
        .CLOCK_50       (clk),
        .reset          (rst),
        .read_ready     (read_ready),
        .write_ready    (write_ready),
        .readdata_left  (readdata_left),
        .readdata_right (readdata_right),
        .read           (read),
        .write          (write),
        .writedata_left (writedata_left),
        .writedata_right(writedata_right),
        .fir_start      (fir_start),
        .fir_in         (fir_in),
        .fir_done       (fir_done),
        .fir_out        (fir_out),
        .fir_error      (fir_error),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // FIR engine model: answers fir_start after the channel's delay with fir_out = fir_in + 1.
    initial begin
        logic signed [15:0] cap;
        int d;
        fir_done = 1'b0;
        fir_out  = '0;
        forever begin
            @(negedge clk);
            fir_done = stray_req;
            if (stray_req) fir_out = 16'sh7777;
            stray_req = 1'b0;
            if (fir_start && !rst) begin
                cap = fir_in;
                d   = tb_chan ? d_r : d_l;
                chk("fir_in", fir_in, tb_chan ? exp_in_r : exp_in_l);
                tb_chan = ~tb_chan;
                if (d <= TO) begin
                    for (int i = 1; i < d; i++) begin
                        @(negedge clk);
                        fir_done = 1'b0;
                        chk("fir_in_hold", fir_in, cap);
                    end
                    @(negedge clk);
                    fir_done = 1'b1;
                    fir_out  = cap + 16'sd1;
                end
            end
        end
    end

    // Output monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && read) begin
                read_cyc = cyc;
                read_cnt++;
            end
            if (!rst && write) begin
                write_cnt++;
                chk("rw_excl", read, 0);
                if (sb.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("wd_left", writedata_left, e.wd_l);
                    chk("wd_right", writedata_right, e.wd_r);
                    if (e.lat >= 0) chk("latency", cyc - read_cyc, e.lat);
                end
            end
        end
    end

    function automatic logic [23:0] exp_wd(input logic [23:0] smp, input int d);
        logic [15:0] s;
        s = smp[23:8];
        if (d <= TO) s = s + 16'd1;
        return {s, 8'h00};
    endfunction

    task automatic start_txn(input logic [23:0] l, input logic [23:0] r,
                             input int dl, input int dr, input int lat);
        exp_t e;
        d_l = dl;
        d_r = dr;
        exp_in_l = l[23:8];
        exp_in_r = r[23:8];
        e.wd_l = exp_wd(l, dl);
        e.wd_r = exp_wd(r, dr);
        e.lat  = lat;
        sb.push_back(e);
        @(negedge clk);
        readdata_left  = l;
        readdata_right = r;
        read_ready     = 1'b1;
    endtask

    task automatic wait_read();
        int k;
        for (k = 0; k < 20; k++) begin
            @(posedge clk);
            #2;
            if (read) break;
        end
        if (k == 20) chk("read_timeout", 0, 1);
    endtask

    task automatic wait_empty();
        int k;
        for (k = 0; k < 400; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        chk("txn_done", sb.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic run_txn(input logic [23:0] l, input logic [23:0] r, input int dl, input int dr);
        int ml, mr;
        ml = (dl < TO) ? dl : TO;
        mr = (dr < TO) ? dr : TO;
        start_txn(l, r, dl, dr, 4 + ml + mr);
        wait_read();
        read_ready = 1'b0;
        wait_empty();
    endtask

    initial begin
        int rc, wc;
        rst = 1'b1;
        read_ready = 1'b0;
        write_ready = 1'b1;
        readdata_left = '0;
        readdata_right = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {read, write, fir_start, fir_in, writedata_left, writedata_right},
            '0);
        chk("rst_err", {fir_error, err_count}, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Basic pair, minimum latency.
        run_txn(24'h123400, 24'hFEDC00, 1, 1);
        run_txn(24'h800000, 24'h7FFF00, 3, 7);

        // Stray fir_done while idle must not disturb anything.
        @(posedge clk);
        stray_req = 1'b1;
        repeat (4) @(posedge clk);
        chk("stray_no_read", read_cnt, 2);
        run_txn(24'h0100AB, 24'hFFFFCD, 2, 1);
        chk("err_clean", fir_error, 0);

        // fir_done lands exactly on the timeout cycle: done wins.
        run_txn(24'h4242FF, 24'h1111EE, TO, TO);
        chk("coincide_no_err", fir_error, 0);
        chk("coincide_cnt", err_count, 0);

        // Left channel never answered.
        run_txn(24'h5A5A00, 24'h3C3C00, 200, 1);
        chk("to_err", fir_error, 1);
`ifdef SEQ_ERRCNT_EN
        chk("to_cnt", err_count, 1);
`else
        chk("to_cnt", err_count, 0);
`endif

        // Reset during WAIT_R aborts the pair.
        start_txn(24'hABCD00, 24'hDCBA00, 1, 200, -1);
        wait_read();
        read_ready = 1'b0;
        repeat (6) @(negedge clk);
        wc = write_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_outputs", {read, write, fir_start, fir_in, writedata_left, writedata_right},
            '0);
        chk("midrst_err", {fir_error, err_count}, '0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        tb_chan = 1'b0;
        repeat (80) @(posedge clk);
        chk("midrst_no_write", write_cnt, wc);
        run_txn(24'h600D00, 24'hF00D00, 1, 1);

        // Codec write stalled with read_ready held high.
        rc = read_cnt;
        write_ready = 1'b0;
        start_txn(24'h246800, 24'h135700, 2, 2, -1);
        repeat (50) @(posedge clk);
        #1;
        chk("stall_wd_l_a", writedata_left, 24'h246900);
        repeat (50) @(posedge clk);
        #1;
        chk("stall_wd_l_b", writedata_left, 24'h246900);
        chk("stall_wd_r", writedata_right, 24'h135800);
        chk("stall_one_read", read_cnt - rc, 1);
        chk("stall_no_write", write_cnt, wc + 1);
        @(negedge clk);
        read_ready = 1'b0;
        write_ready = 1'b1;
        wait_empty();
        chk("stall_reads_after", read_cnt - rc, 1);

        // Forced timeouts on both channels: 300 events.
        for (int i = 0; i < 150; i++)
            run_txn(24'(i * 256 + 24'h010000), 24'(24'hFF0000 - i * 256), 300, 300);
        chk("sat_err", fir_error, 1);
`ifdef SEQ_ERRCNT_EN
        chk("sat_cnt", err_count, 255);
`else
        chk("sat_cnt", err_count, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
